mult_issue_ctrl: RTL and testbench

- Front-end controller for the OOO core's 2-stage pipelined 32x32 unsigned Wallace multiplier (actual_mult). Implements RV32M MUL/MULH/MULHSU/MULHU on top of it.
- Accepts ops from the issue stage via valid/ready and converts signed operands to magnitudes. Holds operands stable for the multiplier's full latency, fixes the result sign and selects the half.
- Returns a tagged result via valid/ready and honours pipeline flush.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/actual_mult.sv | 55 +++++
 rtl/mult_issue_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mult_issue_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier issue controller and its datapath.
package mult_pkg;

    localparam int MULT_LAT_DEFAULT = 2;

    // Encoding matches funct3[1:0] of the RV32M multiply group.
    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mult_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mult_state_t;

endpackage

// File: rtl/actual_mult.sv
// Pipelined 32x32 unsigned multiplier: registered 16x16 partial products followed by
// LAT-1 result stages. Inputs must stay constant for LAT+1 cycles.
module actual_mult
    import mult_pkg::*;
#(
    parameter int LAT = MULT_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] prod_o
);

    logic [31:0] pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
    logic [63:0] sum;
    logic [63:0] stage_q [LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pp_ll_q <= '0;
            pp_lh_q <= '0;
            pp_hl_q <= '0;
            pp_hh_q <= '0;
        end else begin
            pp_ll_q <= a_i[15:0]  * b_i[15:0];
            pp_lh_q <= a_i[15:0]  * b_i[31:16];
            pp_hl_q <= a_i[31:16] * b_i[15:0];
            pp_hh_q <= a_i[31:16] * b_i[31:16];
        end
    end

    assign sum = {32'd0, pp_ll_q}
               + {16'd0, pp_lh_q, 16'd0}
               + {16'd0, pp_hl_q, 16'd0}
               + {pp_hh_q, 32'd0};

    // NOTE: the stage array is only a few words deep, so every entry is reset; a bare
    // reset keeps the product output defined instead of carrying X into the controller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT - 1; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= sum;
            for (int i = 1; i < LAT - 1; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign prod_o = stage_q[LAT-2];

endmodule

// File: rtl/mult_issue_ctrl.sv
// RV32M multiply front-end: sign handling, operand hold and tagged response around actual_mult.
// Optional build macro MULT_PERF_CNT_EN adds the perf_ops / perf_stall counters.
module mult_issue_ctrl
    import mult_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int TAG_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag
`ifdef MULT_PERF_CNT_EN
    ,
    output logic [31:0]      perf_ops,
    output logic [31:0]      perf_stall
`endif
);

    localparam int CNT_W = $clog2(MULT_LAT + 1);

    mult_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      op_a_q, op_b_q;
    mult_op_t         op_q;
    logic [TAG_W-1:0] tag_q;
    logic             neg_q;
    logic [31:0]      resp_data_q, resp_data_d;
    logic [TAG_W-1:0] resp_tag_q;

    mult_op_t         req_op_e;
    logic             accept, resp_fire, capture;
    logic             neg_a, neg_b;
    logic [31:0]      mag_a, mag_b;
    logic [63:0]      prod, prod_fix;

    assign req_op_e  = mult_op_t'(req_op);
    assign req_ready = !rst && !flush && (state_q == IDLE || (state_q == DONE && resp_ready));
    assign resp_valid = (state_q == DONE) && !flush;
    assign accept    = req_valid && req_ready;
    assign resp_fire = resp_valid && resp_ready;
    assign resp_data = resp_data_q;
    assign resp_tag  = resp_tag_q;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign neg_a = (req_op_e == MULH || req_op_e == MULHSU) && req_a[31];
    assign neg_b = (req_op_e == MULH) && req_b[31];
    assign mag_a = neg_a ? (~req_a + 32'd1) : req_a;
    assign mag_b = neg_b ? (~req_b + 32'd1) : req_b;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(MULT_LAT)) begin
                    state_d = DONE;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (resp_fire) begin
                    state_d = accept ? BUSY : IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            capture = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operands are frozen from accept until the next accept, covering all of BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q <= '0;
            op_b_q <= '0;
            op_q   <= MUL;
            tag_q  <= '0;
            neg_q  <= 1'b0;
        end else if (accept) begin
            op_a_q <= mag_a;
            op_b_q <= mag_b;
            op_q   <= req_op_e;
            tag_q  <= req_tag;
            neg_q  <= neg_a ^ neg_b;
        end
    end

    actual_mult #(
        .LAT    (MULT_LAT)
    ) u_actual_mult (
        .clk    (clk),
        .rst    (rst),
        .a_i    (op_a_q),
        .b_i    (op_b_q),
        .prod_o (prod)
    );

    assign prod_fix    = neg_q ? (~prod + 64'd1) : prod;
    assign resp_data_d = (op_q == MUL) ? prod_fix[31:0] : prod_fix[63:32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_data_q <= '0;
            resp_tag_q  <= '0;
        end else if (capture) begin
            resp_data_q <= resp_data_d;
            resp_tag_q  <= tag_q;
        end
    end

`ifdef MULT_PERF_CNT_EN
    logic [31:0] perf_ops_q, perf_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (resp_fire) perf_ops_q <= perf_ops_q + 32'd1;
            if (resp_valid && !resp_ready) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Self-checking bench for mult_issue_ctrl: vector table, scoreboard, and corner sequences
// for backpressure, flush and mid-operation reset.
module tb_mult_issue_ctrl;
    import mult_pkg::*;

    localparam int TAG_W = 6;

    logic             clk = 1'b0;
    logic             rst, flush, req_valid, req_ready, resp_valid, resp_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_a, req_b, resp_data;
    logic [TAG_W-1:0] req_tag, resp_tag;
`ifdef MULT_PERF_CNT_EN
    logic [31:0]      perf_ops, perf_stall;
`endif

    always #5 clk = ~clk;

    mult_issue_ctrl #(
        .MULT_LAT   (2),
        .TAG_W      (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag)
`ifdef MULT_PERF_CNT_EN
        ,
        .perf_ops   (perf_ops),
        .perf_stall (perf_stall)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: expected event did not occur", name);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent reference: 33-bit sign/zero-extended operands multiplied as signed.
    function automatic logic [31:0] ref_mult(input mult_op_t op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [32:0] sa, sb;
        logic signed [65:0] p;
        sa = (op == MULH || op == MULHSU) ? {a[31], a} : {1'b0, a};
        sb = (op == MULH) ? {b[31], b} : {1'b0, b};
        p  = sa * sb;
        return (op == MUL) ? p[31:0] : p[63:32];
    endfunction

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   exp_ops   = 0;
    int   exp_stall = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_ops   = 0;
            exp_stall = 0;
        end else begin
            if (resp_valid && !resp_ready) exp_stall++;
            if (resp_valid && resp_ready) begin
                exp_ops++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: tag 0x%0h data 0x%0h, expected none",
                             resp_tag, resp_data);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("resp_data", resp_data, mon_e.data);
                    check("resp_tag", resp_tag, mon_e.tag);
                end
            end
        end
    end

    // Called just after a posedge; returns just after the accept edge.
    task automatic send(input mult_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input bit expect_resp,
                        input logic [31:0] exp_data);
        int w = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        @(negedge clk);
        while (!req_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) fail_now("req_ready_timeout");
        else if (expect_resp) sb_q.push_back('{data: exp_data, tag: tag});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Edges after the accept edge until resp_valid is seen.
    task automatic wait_resp(output int lat);
        lat = 0;
        @(negedge clk);
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) fail_now("resp_valid_timeout");
    endtask

    task automatic run_vec(input mult_op_t op, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag, input logic [31:0] exp_data);
        int lat;
        @(posedge clk);
        #1;
        send(op, a, b, tag, 1'b1, exp_data);
        wait_resp(lat);
        check("latency", lat, 3);
        @(negedge clk);
        check("resp_pulse_width", resp_valid, 1'b0);
    endtask

    typedef struct {
        mult_op_t    op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int lat, seen;
        mult_op_t rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1]  = '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
        vecs[3]  = '{MUL,    32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA};
        vecs[4]  = '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[5]  = '{MULH,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[6]  = '{MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
        vecs[7]  = '{MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
        vecs[8]  = '{MULHSU, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[9]  = '{MULH,   32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000};
        vecs[10] = '{MULH,   32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        vecs[11] = '{MULHSU, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001};

        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        req_op     = 2'b00;
        req_a      = '0;
        req_b      = '0;
        req_tag    = '0;
        #1;
        check("reset_resp_valid", resp_valid, 1'b0);
        check("reset_resp_data", resp_data, 32'd0);
        check("reset_resp_tag", resp_tag, '0);
        check("reset_req_ready", req_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", req_ready, 1'b1);
`ifdef MULT_PERF_CNT_EN
        check("reset_perf_ops", perf_ops, 32'd0);
`endif

        foreach (vecs[i]) begin
            run_vec(vecs[i].op, vecs[i].a, vecs[i].b, TAG_W'(i + 1), vecs[i].exp);
        end

        for (int i = 0; i < 6; i++) begin
            rop = mult_op_t'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            run_vec(rop, ra, rb, TAG_W'(20 + i), ref_mult(rop, ra, rb));
        end

        // Backpressure in DONE, then a same-cycle handshake and accept.
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        send(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd40, 1'b1, 32'hFFFF_FFFE);
        wait_resp(lat);
        check("bp_latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_resp_valid", resp_valid, 1'b1);
            check("bp_resp_data", resp_data, 32'hFFFF_FFFE);
            check("bp_resp_tag", resp_tag, 6'd40);
            check("bp_req_ready", req_ready, 1'b0);
        end
`ifdef MULT_PERF_CNT_EN
        check("bp_perf_stall", perf_stall, 32'(exp_stall));
`endif
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_op     = MUL;
        req_a      = 32'hFFFF_FFFE;
        req_b      = 32'h0000_0003;
        req_tag    = 6'd41;
        @(negedge clk);
        check("bp_same_cycle_resp_valid", resp_valid, 1'b1);
        check("bp_same_cycle_req_ready", req_ready, 1'b1);
        sb_q.push_back('{data: 32'hFFFF_FFFA, tag: 6'd41});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_resp(lat);
        check("bp_next_latency", lat, 3);
        @(negedge clk);
        check("bp_next_pulse_width", resp_valid, 1'b0);

        // Flush on the second BUSY cycle drops the op.
        @(posedge clk);
        #1;
        send(MULH, 32'h1234_5678, 32'h0000_0009, 6'd50, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_req_ready", req_ready, 1'b0);
        check("flush_resp_valid", resp_valid, 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("post_flush_req_ready", req_ready, 1'b1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("flush_no_resp", seen, 0);
        run_vec(MULHU, 32'd7, 32'd9, 6'd51, 32'h0000_0000);
        run_vec(MUL, 32'd7, 32'd9, 6'd52, 32'h0000_003F);

        // Reset pulse while BUSY: outputs clear without waiting for a clock edge.
        @(posedge clk);
        #1;
        send(MUL, 32'd5, 32'd6, 6'd60, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_resp_valid", resp_valid, 1'b0);
        check("rst_mid_resp_data", resp_data, 32'd0);
        check("rst_mid_resp_tag", resp_tag, '0);
        check("rst_mid_req_ready", req_ready, 1'b0);
`ifdef MULT_PERF_CNT_EN
        check("rst_mid_perf_ops", perf_ops, 32'd0);
        check("rst_mid_perf_stall", perf_stall, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("rst_no_resp", seen, 0);
        run_vec(MULH, 32'hFFFF_FFFF, 32'h0000_0001, 6'd61, 32'hFFFF_FFFF);
`ifdef MULT_PERF_CNT_EN
        check("perf_ops_after_rst", perf_ops, 32'd1);
        check("perf_stall_after_rst", perf_stall, 32'd0);
`endif
        run_vec(MULHU, 32'h0001_0000, 32'h0001_0000, 6'd62, 32'h0000_0001);
`ifdef MULT_PERF_CNT_EN
        check("perf_ops_increment", perf_ops, 32'd2);
        check("perf_ops_model", perf_ops, 32'(exp_ops));
`endif

        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
